// File: rtl/iir_biquad_cascade_axis.sv
// Cascade of NUM_SECTIONS DF1 biquads on one time-multiplexed MAC, AXI-Stream in/out.
// Define IIR_SAT_EN for saturating section outputs plus a sticky ovf port; otherwise outputs wrap.
module iir_biquad_cascade_axis #(
   parameter int DATA_W       = 16,
   parameter int COEF_W       = 16,
   parameter int FRAC_BITS    = 14,
   parameter int NUM_SECTIONS = 2,
   parameter int ACC_W        = DATA_W + COEF_W + 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [DATA_W-1:0]                   s_axis_tdata,
   input  logic                                s_axis_tvalid,
   output logic                                s_axis_tready,
   output logic [DATA_W-1:0]                   m_axis_tdata,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   input  logic                                coef_we,
   input  logic [$clog2(5*NUM_SECTIONS)-1:0]   coef_addr,
   input  logic [COEF_W-1:0]                   coef_wdata,
`ifdef IIR_SAT_EN
   output logic                                ovf,
`endif
   output logic                                coef_err
);
   localparam int NCOEF = 5 * NUM_SECTIONS;
   localparam int CW    = $clog2(NCOEF);
   localparam int KW    = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
   localparam int PW    = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_BITS - 1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                      state_q;
   logic signed [DATA_W-1:0]    x1_q [NUM_SECTIONS];
   logic signed [DATA_W-1:0]    x2_q [NUM_SECTIONS];
   logic signed [DATA_W-1:0]    y1_q [NUM_SECTIONS];
   logic signed [DATA_W-1:0]    y2_q [NUM_SECTIONS];
   logic signed [COEF_W-1:0]    coef_q [NCOEF];
   logic signed [DATA_W-1:0]    xin_q;
   logic signed [ACC_W-1:0]     acc_q;
   logic [2:0]                  p_q;
   logic [KW-1:0]               k_q;
   logic [CW-1:0]               idx_q;
   logic [DATA_W-1:0]           m_data_q;
   logic                        m_valid_q, s_ready_q, coef_err_q;

   logic signed [DATA_W-1:0]    operand_d;
   logic signed [PW-1:0]        prod_d;
   logic signed [ACC_W-1:0]     sum_d, rnd_d;
   logic signed [DATA_W-1:0]    y_d;
   logic                        addr_ok_d;
`ifdef IIR_SAT_EN
   localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] YMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   logic signed [ACC_W-1:0]     shifted_d;
   logic                        sat_d, ovf_q;
   assign ovf = ovf_q;
`endif

   assign s_axis_tready = s_ready_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign coef_err      = coef_err_q;
   assign addr_ok_d     = coef_addr < CW'(NCOEF);

   // Phases 0..4 pair b0,b1,b2,a1,a2 with x,x1,x2,y1,y2; feedback terms are subtracted.
   always_comb begin
      operand_d = xin_q;
      case (p_q)
         3'd1:    operand_d = x1_q[k_q];
         3'd2:    operand_d = x2_q[k_q];
         3'd3:    operand_d = y1_q[k_q];
         3'd4:    operand_d = y2_q[k_q];
         default: operand_d = xin_q;
      endcase
      prod_d = PW'(coef_q[idx_q]) * PW'(operand_d);
      sum_d  = (p_q >= 3'd3) ? acc_q - ACC_W'(prod_d) : acc_q + ACC_W'(prod_d);
      rnd_d  = sum_d + RND;
`ifdef IIR_SAT_EN
      shifted_d = rnd_d >>> FRAC_BITS;
      sat_d     = 1'b0;
      y_d       = shifted_d[DATA_W-1:0];
      if (shifted_d > YMAX) begin
         y_d   = YMAX[DATA_W-1:0];
         sat_d = 1'b1;
      end else if (shifted_d < YMIN) begin
         y_d   = YMIN[DATA_W-1:0];
         sat_d = 1'b1;
      end
`else
      y_d = DATA_W'(rnd_d >>> FRAC_BITS);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         xin_q      <= '0;
         acc_q      <= '0;
         p_q        <= '0;
         k_q        <= '0;
         idx_q      <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         s_ready_q  <= 1'b1;
         coef_err_q <= 1'b0;
`ifdef IIR_SAT_EN
         ovf_q      <= 1'b0;
`endif
         for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
            x1_q[i] <= '0;
            x2_q[i] <= '0;
            y1_q[i] <= '0;
            y2_q[i] <= '0;
         end
         for (int unsigned i = 0; i < NCOEF; i++)
            coef_q[i] <= (i % 5 == 0) ? COEF_W'(1) << FRAC_BITS : '0;
      end else begin
         coef_err_q <= coef_we && (state_q != IDLE || !addr_ok_d);
         if (coef_we && state_q == IDLE && addr_ok_d)
            coef_q[coef_addr] <= coef_wdata;
         case (state_q)
            IDLE: if (s_axis_tvalid) begin
               xin_q     <= s_axis_tdata;
               acc_q     <= '0;
               p_q       <= '0;
               k_q       <= '0;
               idx_q     <= '0;
               s_ready_q <= 1'b0;
               state_q   <= MAC;
            end
            MAC: begin
               idx_q <= idx_q + CW'(1);
               if (p_q == 3'd4) begin
                  x2_q[k_q] <= x1_q[k_q];
                  x1_q[k_q] <= xin_q;
                  y2_q[k_q] <= y1_q[k_q];
                  y1_q[k_q] <= y_d;
                  xin_q     <= y_d;
                  acc_q     <= '0;
                  p_q       <= '0;
`ifdef IIR_SAT_EN
                  ovf_q     <= ovf_q | sat_d;
`endif
                  if (k_q == KW'(NUM_SECTIONS - 1)) begin
                     m_data_q  <= y_d;
                     m_valid_q <= 1'b1;
                     state_q   <= OUT;
                  end else begin
                     k_q <= k_q + KW'(1);
                  end
               end else begin
                  acc_q <= sum_d;
                  p_q   <= p_q + 3'd1;
               end
            end
            OUT: if (m_axis_tready) begin
               m_valid_q <= 1'b0;
               s_ready_q <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iir_biquad_cascade_axis.sv
// Scoreboard bench for iir_biquad_cascade_axis at default parameters (2 sections, Q1.14).
module tb_iir_biquad_cascade_axis;
   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic [15:0]       m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              coef_we;
   logic [3:0]        coef_addr;
   logic [15:0]       coef_wdata;
   logic              coef_err;
`ifdef IIR_SAT_EN
   logic              ovf;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   logic [15:0] exp_q[$];

   iir_biquad_cascade_axis #(.DATA_W(16), .COEF_W(16), .FRAC_BITS(14), .NUM_SECTIONS(2)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
`ifdef IIR_SAT_EN
      .ovf(ovf),
`endif
      .coef_err(coef_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
      coef_we = 1'b1; coef_addr = a; coef_wdata = d;
      tick();
      coef_we = 1'b0;
   endtask

   // Returns just after the input handshake edge; hs is the cycle count at that edge.
   task automatic drive_in(input logic [15:0] x, output bit ok, output int unsigned hs);
      ok = 1'b0; hs = 0;
      s_tdata = x; s_tvalid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (s_tready) begin
            tick();
            ok = 1'b1;
            hs = cyc;
         end else tick();
      end
      s_tvalid = 1'b0;
   endtask

   // Waits for m_tvalid; lat counts cycles from the call. Consumes the beat if m_tready is high.
   task automatic wait_out(output logic [15:0] d, output int lat, output bit ok);
      lat = 0;
      while (!m_tvalid && lat < 200) begin
         tick();
         lat++;
      end
      ok = m_tvalid;
      d  = m_tdata;
      if (ok && m_tready) tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b want=0", m_tvalid); end
      total++; if (m_tdata !== 16'd0) begin bad++; $display("FAIL rst_mdata got=%0d want=0", m_tdata); end
      total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL rst_sready got=%b want=1", s_tready); end
      total++; if (coef_err !== 1'b0) begin bad++; $display("FAIL rst_coeferr got=%b want=0", coef_err); end
`ifdef IIR_SAT_EN
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf); end
`endif
   endtask

   task automatic test_passthrough();
      logic [15:0] ins[2] = '{16'd1234, 16'h8000};
      logic [15:0] d, e;
      int lat; bit ok; int unsigned hs;
      m_tready = 1'b1;
      foreach (ins[i]) begin
         exp_q.push_back(ins[i]);
         drive_in(ins[i], ok, hs);
         wait_out(d, lat, ok);
         e = exp_q.pop_front();
         total++; if (!ok || d !== e) begin bad++; $display("FAIL pass_data got=%0d want=%0d", $signed(d), $signed(e)); end
         total++; if (lat != 10) begin bad++; $display("FAIL pass_latency got=%0d want=10", lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] d, e;
      int lat; bit ok, stable; int unsigned hs, prev_hs;
      m_tready = 1'b0;
      exp_q.push_back(16'd777);
      drive_in(16'd777, ok, hs);
      wait_out(d, lat, ok);
      e = exp_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL bp_data got=%0d want=%0d", d, e); end
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_tdata !== e || m_tvalid !== 1'b1 || s_tready !== 1'b0) stable = 1'b0;
      end
      total++; if (!stable) begin bad++; $display("FAIL bp_hold got=%0d/%b/%b want=%0d/1/0", m_tdata, m_tvalid, s_tready, e); end
      m_tready = 1'b1;
      tick();
      total++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
         bad++; $display("FAIL bp_release got=%b/%b want=0/1", m_tvalid, s_tready); end
      prev_hs = 0;
      for (int i = 0; i < 5; i++) begin
         logic [15:0] x;
         x = 16'(i * 4099 - 9000);
         exp_q.push_back(x);
         drive_in(x, ok, hs);
         if (i > 0) begin
            total++; if (hs - prev_hs != 12) begin bad++; $display("FAIL stream_rate got=%0d want=12", hs - prev_hs); end
         end
         prev_hs = hs;
         wait_out(d, lat, ok);
         e = exp_q.pop_front();
         total++; if (!ok || d !== e) begin bad++; $display("FAIL stream_data got=%0d want=%0d", $signed(d), $signed(e)); end
      end
   endtask

   task automatic test_fir();
      logic [15:0] d, e;
      int lat; bit ok; int unsigned hs;
      do_reset();
      write_coef(4'd0, 16'd8192);
      write_coef(4'd1, 16'd8192);
      exp_q = '{16'd8192, 16'd8192, 16'd0, 16'd0};
      for (int i = 0; i < 4; i++) begin
         drive_in((i == 0) ? 16'd16384 : 16'd0, ok, hs);
         wait_out(d, lat, ok);
         e = exp_q.pop_front();
         total++; if (!ok || d !== e) begin bad++; $display("FAIL fir[%0d] got=%0d want=%0d", i, $signed(d), $signed(e)); end
      end
   endtask

   task automatic test_feedback();
      logic [15:0] d, e;
      int lat; bit ok; int unsigned hs;
      do_reset();
      write_coef(4'd3, 16'hE000);
      exp_q = '{16'd16384, 16'd8192, 16'd4096, 16'd2048, 16'd1024};
      for (int i = 0; i < 5; i++) begin
         drive_in((i == 0) ? 16'd16384 : 16'd0, ok, hs);
         wait_out(d, lat, ok);
         e = exp_q.pop_front();
         total++; if (!ok || d !== e) begin bad++; $display("FAIL iir[%0d] got=%0d want=%0d", i, $signed(d), $signed(e)); end
      end
      // With the same feedback restored, any surviving y1 would leak into this output.
      do_reset();
      write_coef(4'd3, 16'hE000);
      exp_q.push_back(16'd0);
      drive_in(16'd0, ok, hs);
      wait_out(d, lat, ok);
      e = exp_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL iir_cleared got=%0d want=%0d", $signed(d), $signed(e)); end
   endtask

   task automatic test_overflow();
      logic [15:0] d, e;
      int lat; bit ok; int unsigned hs;
      do_reset();
      write_coef(4'd0, 16'd32767);
`ifdef IIR_SAT_EN
      exp_q.push_back(16'd32767);
`else
      exp_q.push_back(16'hFFFC);
`endif
      drive_in(16'd32767, ok, hs);
      wait_out(d, lat, ok);
      e = exp_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL ovf_data got=%0d want=%0d", $signed(d), $signed(e)); end
`ifdef IIR_SAT_EN
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ovf); end
`endif
   endtask

   task automatic test_busy_write();
      logic [15:0] d, e;
      int lat; bit ok, never; int unsigned hs;
      do_reset();
      exp_q.push_back(16'd100);
      drive_in(16'd100, ok, hs);
      coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'd0;
      tick();
      coef_we = 1'b0;
      total++; if (coef_err !== 1'b1) begin bad++; $display("FAIL busy_err got=%b want=1", coef_err); end
      tick();
      total++; if (coef_err !== 1'b0) begin bad++; $display("FAIL busy_err_pulse got=%b want=0", coef_err); end
      wait_out(d, lat, ok);
      e = exp_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL busy_data got=%0d want=%0d", d, e); end
      exp_q.push_back(16'd555);
      drive_in(16'd555, ok, hs);
      wait_out(d, lat, ok);
      e = exp_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL busy_b0_kept got=%0d want=%0d", d, e); end
      write_coef(4'd10, 16'd0);
      total++; if (coef_err !== 1'b1) begin bad++; $display("FAIL badaddr_err got=%b want=1", coef_err); end
      exp_q.push_back(16'd321);
      drive_in(16'd321, ok, hs);
      wait_out(d, lat, ok);
      e = exp_q.pop_front();
      total++; if (!ok || d !== e) begin bad++; $display("FAIL badaddr_data got=%0d want=%0d", d, e); end
      drive_in(16'd999, ok, hs);
      tick(); tick(); tick();
      do_reset();
      total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL abort_sready got=%b want=1", s_tready); end
      never = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (m_tvalid) never = 1'b0;
         tick();
      end
      total++; if (!never) begin bad++; $display("FAIL abort_mvalid got=1 want=0"); end
   endtask

   initial begin
      rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
      #1;
      test_reset();
      test_passthrough();
      test_backpressure();
      test_fir();
      test_feedback();
      test_overflow();
      test_busy_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/iir_biquad_cascade_axis.md
Name: iir_biquad_cascade_axis

Overview:
Parametrised cascade of NUM_SECTIONS Direct Form 1 biquad sections with full AXI-Stream handshakes on both sides. A single time-multiplexed MAC serves every section, five products per section. Coefficients are runtime-writable through a simple register port and default to pass-through. It replaces the single fixed biquad in the sample-rate filter chain.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
FRAC_BITS, 14, coefficient fractional bits (Q(COEF_W-FRAC_BITS-1).FRAC_BITS)
NUM_SECTIONS, 2, number of cascaded biquads (1..8)
ACC_W, DATA_W+COEF_W+4, accumulator width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_W  input sample
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  filtered sample
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(5*NUM_SECTIONS)  coefficient index
coef_wdata  in  COEF_W  coefficient value
coef_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst high on a clk edge): FSM goes to IDLE. All delay lines (x1,x2,y1,y2 per section) are cleared to 0. Accumulator is 0. m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1 after reset, coef_err=0. Coefficients reload to defaults: b0=1<<FRAC_BITS, b1=b2=a1=a2=0 for every section. Reset mid-computation aborts the sample and drops it.
- Coefficient map: addr 5k+0..4 = b0,b1,b2,a1,a2 of section k. Addresses at or above 5*NUM_SECTIONS are ignored and pulse coef_err.
- Per-section equation: y = sat(round((b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >> FRAC_BITS)).
- Rounding: add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
- FSM states and transitions:
  - IDLE: s_axis_tready=1. A transfer (tvalid & tready) latches the input as section 0's x, clears the accumulator and goes to MAC.
  - MAC: one product per cycle, with phase counter p=0..4 and section counter k. At p=4 the rounded and saturated y is registered. Section k's delay lines shift (x2<=x1, x1<=x, y2<=y1, y1<=y). y becomes the x of section k+1 and the accumulator clears. After the last section, y is loaded into m_axis_tdata and the FSM goes to OUT.
  - OUT: m_axis_tvalid=1 and m_axis_tdata is held stable until m_axis_tready=1. On that handshake edge m_axis_tvalid drops and the FSM goes to IDLE, so s_axis_tready=1 on the next cycle.
- Latency: m_axis_tvalid rises exactly 5*NUM_SECTIONS cycles after the input handshake edge (10 cycles at the default).
- Throughput: one sample per 5*NUM_SECTIONS+2 cycles when m_axis_tready is held high.
- s_axis_tready=0 in MAC and OUT, so no sample is ever lost under backpressure.
- Coefficient writes: accepted only in IDLE and take effect the next cycle. A write in MAC or OUT is ignored and coef_err pulses for one cycle.
- If coef_we and an input handshake occur in the same IDLE cycle, the write is applied and the sample uses the new value.

Optional Feature:
IIR_SAT_EN
- Defined:
  - Every section output saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Adds output port ovf (1 bit): sticky, set whenever any section saturates, cleared only by rst.
- Undefined:
  - No saturation; the output keeps the low DATA_W bits (two's-complement wrap).
  - No ovf port.

Test Plan:
1. After reset, input 1234, m_axis_tready=1 -> m_axis_tdata=1234 with m_axis_tvalid high exactly 10 cycles after the handshake. Input -32768 -> -32768.
2. Backpressure: m_axis_tready=0 for 20 cycles in OUT -> m_axis_tdata stable, s_axis_tready=0 throughout. Release -> one output handshake, s_axis_tready=1 next cycle. A 5-sample stream arrives unchanged and in order.
3. FIR path: write section 0 b0=8192, b1=8192. Impulse 16384, then zeros -> outputs 8192, 8192, 0, 0.
4. Feedback path: write section 0 a1=-8192. Impulse 16384, then zeros -> outputs 16384, 8192, 4096, 2048, 1024. Then assert rst and send 0 -> output 0 (delay lines cleared).
5. Overflow: write section 0 b0=32767. Input 32767 ->
   - IIR_SAT_EN defined: output 32767, ovf=1.
   - IIR_SAT_EN undefined: output -4.
6. Write during busy: coef_we with addr 0 in MAC -> coef_err pulses once, b0 unchanged (next pass-through sample is exact). Write to addr 10 in IDLE -> coef_err pulses. rst asserted mid-MAC -> m_axis_tvalid never rises for that sample, s_axis_tready=1 after reset.
